// File: rtl/pixel_writer_pkg.sv
// pixel_writer_pkg: shared types and constants for the pixel frame writer.
//   state_e     : controller state encoding (IDLE / RUN / DRAIN)
//   ADDR_STRIDE : byte increment between consecutive pixel words
//   DROP_CNT_MAX: saturation value of the optional drop counter
package pixel_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int unsigned ADDR_STRIDE  = 4;
    localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: small synchronous FIFO with show-ahead head data.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   i_push/i_data: write strobe and word; ignored when full unless popping the same cycle
//   i_pop        : remove head; ignored when empty
//   o_head       : current head word (valid when !o_empty)
//   o_full/o_empty/o_count : occupancy status
module pixel_fifo
    import pixel_writer_pkg::*;
#(
    parameter int unsigned DW         = 31,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FIFO_AW    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [DW:0]      i_data,
    input  logic             i_pop,
    output logic [DW:0]      o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [FIFO_AW:0] o_count
);

    localparam int unsigned CntW = FIFO_AW + 1;

    logic [DW:0]        r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == CntW'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rptr];

    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem   <= '{default: '0};
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + FIFO_AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + FIFO_AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_frame_writer.sv
// pixel_frame_writer: buffers converter pixels in a FIFO and writes them as single
// Avalon-MM writes into a linear frame buffer, one frame per arm.
// Optional feature: define PIXEL_WRITER_DROP_CNT_EN to add the drop_count output.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   enable              : arms capture of the next frame (sampled in IDLE only)
//   clear_overflow      : pulse, clears overflow (and drop_count) unless a drop coincides
//   in_data/in_data_valid/in_sof : pixel stream, no backpressure
//   avm_address/avm_write/avm_writedata/avm_waitrequest : Avalon-MM write master
//   busy                : high while a frame is being captured or drained
//   frame_done          : one-cycle pulse when the last buffered pixel has been written
//   overflow            : sticky, a pixel was dropped because the FIFO was full
//   drop_count          : (optional) saturating count of dropped pixels
module pixel_frame_writer
    import pixel_writer_pkg::*;
#(
    parameter int unsigned DW          = 31,
    parameter int unsigned AW          = 31,
    parameter logic [AW:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned FRAME_WORDS = 76800,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned FIFO_AW     = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          clear_overflow,
    input  logic [DW:0]   in_data,
    input  logic          in_data_valid,
    input  logic          in_sof,
    output logic [AW:0]   avm_address,
    output logic          avm_write,
    output logic [DW:0]   avm_writedata,
    input  logic          avm_waitrequest,
    output logic          busy,
    output logic          frame_done,
    output logic          overflow
`ifdef PIXEL_WRITER_DROP_CNT_EN
    ,
    output logic [15:0]   drop_count
`endif
);

    localparam int unsigned CntW    = $clog2(FRAME_WORDS + 1);
    localparam int unsigned FifoCW  = FIFO_AW + 1;
    localparam int unsigned AddrW   = AW + 1;
    localparam logic [CntW-1:0] LastPix = CntW'(FRAME_WORDS - 1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [CntW-1:0]     r_pix_cnt;
    logic [CntW-1:0]     w_pix_cnt_nxt;
    logic                r_avm_write;
    logic [AW:0]         r_avm_address;
    logic                r_frame_done;
    logic                r_overflow;
    logic                w_take;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic                w_frame_end;
    logic [FIFO_AW:0]    w_fifo_count;
    logic [FIFO_AW:0]    w_count_nxt;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [DW:0]         w_fifo_head;

    pixel_fifo #(
        .DW         (DW),
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // r_avm_write is only ever set while the FIFO holds data, so it doubles as "head valid".
    assign w_pop  = r_avm_write && !avm_waitrequest;
    assign w_push = w_take && (!w_fifo_full || w_pop);
    assign w_drop = w_take && !w_push;

    always_comb begin
        w_state_nxt   = r_state;
        w_pix_cnt_nxt = r_pix_cnt;
        w_take        = 1'b0;
        w_frame_end   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_take = enable && in_data_valid && in_sof;
            end
            ST_RUN: begin
                w_take = in_data_valid;
            end
            ST_DRAIN: begin
                if (w_fifo_empty && !r_avm_write) begin
                    w_frame_end = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Dropped pixels still count so the frame length stays fixed.
        if (w_take) begin
            if (r_pix_cnt == LastPix) begin
                w_pix_cnt_nxt = '0;
                w_state_nxt   = ST_DRAIN;
            end else begin
                w_pix_cnt_nxt = r_pix_cnt + CntW'(1);
                w_state_nxt   = ST_RUN;
            end
        end
    end

    always_comb begin
        w_count_nxt = w_fifo_count;
        if (w_push && !w_pop) begin
            w_count_nxt = w_fifo_count + FifoCW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = w_fifo_count - FifoCW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_pix_cnt     <= '0;
            r_avm_write   <= 1'b0;
            r_avm_address <= BASE_ADDR;
            r_frame_done  <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pix_cnt    <= w_pix_cnt_nxt;
            r_avm_write  <= (w_state_nxt != ST_IDLE) && (w_count_nxt != '0);
            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                r_avm_address <= BASE_ADDR;
            end else if (w_pop) begin
                r_avm_address <= r_avm_address + AddrW'(ADDR_STRIDE);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef PIXEL_WRITER_DROP_CNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_count <= '0;
        end else if (clear_overflow) begin
            r_drop_count <= w_drop ? 16'd1 : 16'd0;
        end else if (w_drop && (r_drop_count != DROP_CNT_MAX)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign avm_write     = r_avm_write;
    assign avm_address   = r_avm_address;
    assign avm_writedata = w_fifo_head;
    assign busy          = (r_state != ST_IDLE);
    assign frame_done    = r_frame_done;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Testbench for pixel_frame_writer: two instances (4- and 8-pixel frames, 4-deep FIFO)
// share stimulus; a negedge monitor checks accepted writes against an expectation queue.
module tb_pixel_frame_writer;

    localparam logic [31:0] Base = 32'h1000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b0;
    logic        clear_overflow = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_data_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        avm_waitrequest = 1'b0;

    logic [31:0] addr4, data4, addr8, data8;
    logic        wr4, wr8, busy4, busy8, done4, done8, ovf4, ovf8;
`ifdef PIXEL_WRITER_DROP_CNT_EN
    logic [15:0] dc4, dc8;
`endif

    always #5 clk = ~clk;

    pixel_frame_writer #(
        .DW(31), .AW(31), .BASE_ADDR(Base), .FRAME_WORDS(4), .FIFO_DEPTH(4), .FIFO_AW(2)
    ) u_dut4 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear_overflow(clear_overflow),
        .in_data(in_data), .in_data_valid(in_data_valid), .in_sof(in_sof),
        .avm_address(addr4), .avm_write(wr4), .avm_writedata(data4),
        .avm_waitrequest(avm_waitrequest), .busy(busy4), .frame_done(done4), .overflow(ovf4)
`ifdef PIXEL_WRITER_DROP_CNT_EN
        , .drop_count(dc4)
`endif
    );

    pixel_frame_writer #(
        .DW(31), .AW(31), .BASE_ADDR(Base), .FRAME_WORDS(8), .FIFO_DEPTH(4), .FIFO_AW(2)
    ) u_dut8 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear_overflow(clear_overflow),
        .in_data(in_data), .in_data_valid(in_data_valid), .in_sof(in_sof),
        .avm_address(addr8), .avm_write(wr8), .avm_writedata(data8),
        .avm_waitrequest(avm_waitrequest), .busy(busy8), .frame_done(done8), .overflow(ovf8)
`ifdef PIXEL_WRITER_DROP_CNT_EN
        , .drop_count(dc8)
`endif
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_acc = 0;
    int          n_done = 0;
    logic        sel8 = 1'b0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Scoreboard: every accepted write must match the oldest expected {address, data}.
    always @(negedge clk) begin : mon
        logic        mw;
        logic        mdone;
        logic [31:0] ma;
        logic [31:0] md;
        mw    = sel8 ? wr8 : wr4;
        mdone = sel8 ? done8 : done4;
        ma    = sel8 ? addr8 : addr4;
        md    = sel8 ? data8 : data4;
        if (reset_n) begin
            if (mw && !avm_waitrequest) begin
                n_acc++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, expected none", ma, md);
                end else begin
                    check("write_addr_data", {ma, md}, exp_q.pop_front());
                end
            end
            if (mdone) n_done++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic vld, input logic sof, input logic [31:0] d);
        enable        = en;
        in_data_valid = vld;
        in_sof        = sof;
        in_data       = d;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        clear_overflow  = 1'b0;
        avm_waitrequest = 1'b0;
        exp_q.delete();
        step();
        step();
        reset_n = 1'b1;
        n_acc   = 0;
        n_done  = 0;
    endtask

    task automatic wait_done(input string name, input int start);
        int k = 0;
        while (n_done == start && k < 40) begin
            step();
            k++;
        end
        check(name, 64'(n_done), 64'(start + 1));
        repeat (3) step();
        check({name, "_single"}, 64'(n_done), 64'(start + 1));
    endtask

    typedef struct {
        logic        en;
        logic        vld;
        logic        sof;
        logic [31:0] data;
        logic        push;
        logic [31:0] addr;
        logic        busy;
        logic        wr;
        logic        done;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic vld, input logic sof,
                                input logic [31:0] data, input logic push,
                                input logic [31:0] addr, input logic busy, input logic wr,
                                input logic done);
        vec_t v;
        v.en = en; v.vld = vld; v.sof = sof; v.data = data; v.push = push; v.addr = addr;
        v.busy = busy; v.wr = wr; v.done = done;
        return v;
    endfunction

    vec_t vec[19];

    initial begin
        // IDLE discard, first frame, two idle cycles after frame_done, second frame.
        vec[0]  = mk(1, 1, 0, 32'h01, 0, 0,       0, 0, 0);
        vec[1]  = mk(0, 1, 1, 32'h02, 0, 0,       0, 0, 0);
        vec[2]  = mk(1, 0, 1, 32'h03, 0, 0,       0, 0, 0);
        vec[3]  = mk(0, 0, 0, 32'h04, 0, 0,       0, 0, 0);
        vec[4]  = mk(1, 1, 1, 32'h0A, 1, 32'h1000, 1, 1, 0);
        vec[5]  = mk(0, 1, 1, 32'h0B, 1, 32'h1004, 1, 1, 0);
        vec[6]  = mk(0, 1, 0, 32'h0C, 1, 32'h1008, 1, 1, 0);
        vec[7]  = mk(1, 1, 0, 32'h0D, 1, 32'h100C, 1, 1, 0);
        vec[8]  = mk(0, 0, 0, 32'h00, 0, 0,       1, 0, 0);
        vec[9]  = mk(0, 0, 0, 32'h00, 0, 0,       0, 0, 1);
        vec[10] = mk(0, 0, 0, 32'h00, 0, 0,       0, 0, 0);
        vec[11] = mk(0, 0, 0, 32'h00, 0, 0,       0, 0, 0);
        vec[12] = mk(1, 1, 1, 32'h11, 1, 32'h1000, 1, 1, 0);
        vec[13] = mk(1, 1, 0, 32'h12, 1, 32'h1004, 1, 1, 0);
        vec[14] = mk(1, 1, 0, 32'h13, 1, 32'h1008, 1, 1, 0);
        vec[15] = mk(1, 1, 0, 32'h14, 1, 32'h100C, 1, 1, 0);
        vec[16] = mk(0, 0, 0, 32'h00, 0, 0,       1, 0, 0);
        vec[17] = mk(0, 0, 0, 32'h00, 0, 0,       0, 0, 1);
        vec[18] = mk(0, 0, 0, 32'h00, 0, 0,       0, 0, 0);

        #2;
        reset_n = 1'b0;
        #1;
        check("rst_write", 64'(wr4), 64'(0));
        check("rst_addr", 64'(addr4), 64'(Base));
        check("rst_data", 64'(data4), 64'(0));
        check("rst_busy", 64'(busy4), 64'(0));
        check("rst_done", 64'(done4), 64'(0));
        check("rst_ovf", 64'(ovf4), 64'(0));
        check("rst_addr8", 64'(addr8), 64'(Base));

        // Table-driven: discard, single frame, back-to-back frame.
        sel8 = 1'b0;
        do_reset();
        for (int i = 0; i < 19; i++) begin
            drive(vec[i].en, vec[i].vld, vec[i].sof, vec[i].data);
            if (vec[i].push) exp_q.push_back({vec[i].addr, vec[i].data});
            step();
            check($sformatf("vec%0d_busy", i), 64'(busy4), 64'(vec[i].busy));
            check($sformatf("vec%0d_write", i), 64'(wr4), 64'(vec[i].wr));
            check($sformatf("vec%0d_done", i), 64'(done4), 64'(vec[i].done));
        end
        drive(0, 0, 0, 32'h0);
        step();
        check("tbl_writes", 64'(n_acc), 64'(8));
        check("tbl_pending", 64'(exp_q.size()), 64'(0));
        check("tbl_done_cnt", 64'(n_done), 64'(2));
        check("tbl_ovf", 64'(ovf4), 64'(0));

        // Waitrequest stall on the second write: address/data held for 4 cycles.
        do_reset();
        drive(1, 1, 1, 32'h0A); exp_q.push_back({32'h1000, 32'h0A}); step();
        drive(0, 1, 0, 32'h0B); exp_q.push_back({32'h1004, 32'h0B}); step();
        for (int c = 0; c < 4; c++) begin
            check($sformatf("stall%0d_write", c), 64'(wr4), 64'(1));
            check($sformatf("stall%0d_addr", c), 64'(addr4), 64'(32'h1004));
            check($sformatf("stall%0d_data", c), 64'(data4), 64'(32'h0B));
            if (c == 0) avm_waitrequest = 1'b1;
            if (c == 3) avm_waitrequest = 1'b0;
            if (c == 0) begin drive(0, 1, 0, 32'h0C); exp_q.push_back({32'h1008, 32'h0C}); end
            if (c == 1) begin drive(0, 1, 0, 32'h0D); exp_q.push_back({32'h100C, 32'h0D}); end
            if (c == 2) drive(0, 0, 0, 32'h0);
            if (c < 3) step();
        end
        wait_done("stall_done", 0);
        check("stall_writes", 64'(n_acc), 64'(4));
        check("stall_pending", 64'(exp_q.size()), 64'(0));
        check("stall_busy", 64'(busy4), 64'(0));
        check("stall_ovf", 64'(ovf4), 64'(0));

        // Overflow on the 8-pixel instance: 4 buffered, 4 dropped.
        sel8 = 1'b1;
        do_reset();
        avm_waitrequest = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1, 1, (k == 0), 32'h20 + 32'(k));
            if (k < 4) exp_q.push_back({Base + 32'(4 * k), 32'h20 + 32'(k)});
            step();
        end
        drive(0, 0, 0, 32'h0);
        check("ovf_set", 64'(ovf8), 64'(1));
        check("ovf_busy", 64'(busy8), 64'(1));
`ifdef PIXEL_WRITER_DROP_CNT_EN
        check("drop_count", 64'(dc8), 64'(4));
`endif
        step();
        step();
        avm_waitrequest = 1'b0;
        wait_done("ovf_done", 0);
        check("ovf_writes", 64'(n_acc), 64'(4));
        check("ovf_pending", 64'(exp_q.size()), 64'(0));
        check("ovf_sticky", 64'(ovf8), 64'(1));
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        check("ovf_cleared", 64'(ovf8), 64'(0));
`ifdef PIXEL_WRITER_DROP_CNT_EN
        check("drop_count_cleared", 64'(dc8), 64'(0));
`endif

        // Reset mid-frame with two entries buffered.
        sel8 = 1'b0;
        do_reset();
        avm_waitrequest = 1'b1;
        drive(1, 1, 1, 32'h3A); step();
        drive(0, 1, 0, 32'h3B); step();
        drive(0, 0, 0, 32'h0);
        check("mid_busy_pre", 64'(busy4), 64'(1));
        check("mid_write_pre", 64'(wr4), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_write", 64'(wr4), 64'(0));
        check("mid_rst_addr", 64'(addr4), 64'(Base));
        check("mid_rst_data", 64'(data4), 64'(0));
        check("mid_rst_busy", 64'(busy4), 64'(0));
        check("mid_rst_done", 64'(done4), 64'(0));
        avm_waitrequest = 1'b0;
        step();
        reset_n = 1'b1;
        n_acc = 0;
        repeat (8) step();
        check("mid_no_writes", 64'(n_acc), 64'(0));
        check("mid_write_post", 64'(wr4), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
